// File: rtl/bridge_arbiter.sv
// Two-master arbiter onto the single system-bridge device bus; one fixed-length
// transaction at a time. Define ARB_FIXED_PRIO_EN for fixed M0 priority (default: round-robin).
module bridge_arbiter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wd,
  input  logic        m0_we,
  input  logic [2:0]  m0_storetype,
  output logic        m0_ready,
  output logic [31:0] m0_rd,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wd,
  input  logic        m1_we,
  input  logic [2:0]  m1_storetype,
  output logic        m1_ready,
  output logic [31:0] m1_rd,
  output logic [31:0] pr_addr,
  output logic [31:0] pr_wd,
  output logic        mem_wr,
  output logic [2:0]  store_type,
  input  logic [31:0] pr_rd,
  output logic [1:0]  gnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] XFER = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  logic [1:0]  state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [1:0]  owner_reg, owner_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wd_reg, wd_next;
  logic        we_reg, we_next;
  logic [2:0]  st_reg, st_next;
  logic [31:0] rd_q_reg, rd_q_next;

  logic [1:0]  req_vec;
  logic [31:0] addr_arr [2];
  logic [31:0] wd_arr   [2];
  logic        we_arr   [2];
  logic [2:0]  st_arr   [2];
  logic [1:0]  ready_vec;
  logic        pick_m1;
  logic        sel;

  assign req_vec  = {m1_req, m0_req};
  assign addr_arr = '{m0_addr, m1_addr};
  assign wd_arr   = '{m0_wd, m1_wd};
  assign we_arr   = '{m0_we, m1_we};
  assign st_arr   = '{m0_storetype, m1_storetype};

`ifdef ARB_FIXED_PRIO_EN
  assign pick_m1 = req_vec[1] && !req_vec[0];
`else
  // last_grant_m1_reg = 1 means M1 was granted most recently, so M0 wins the next tie.
  logic last_grant_m1_reg, last_grant_m1_next;

  assign pick_m1 = req_vec[1] && (!req_vec[0] || !last_grant_m1_reg);
`endif

  assign sel = pick_m1;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    owner_next = owner_reg;
    addr_next  = addr_reg;
    wd_next    = wd_reg;
    we_next    = we_reg;
    st_next    = st_reg;
    rd_q_next  = rd_q_reg;
`ifndef ARB_FIXED_PRIO_EN
    last_grant_m1_next = last_grant_m1_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (|req_vec) begin
          state_next = XFER;
          cnt_next   = 4'd0;
          owner_next = sel ? 2'b10 : 2'b01;
          addr_next  = addr_arr[sel];
          wd_next    = wd_arr[sel];
          we_next    = we_arr[sel];
          st_next    = st_arr[sel];
`ifndef ARB_FIXED_PRIO_EN
          last_grant_m1_next = sel;
`endif
        end
      end
      XFER: begin
        if (cnt_reg == LAST_CNT) begin
          rd_q_next  = pr_rd;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      RESP: begin
        state_next = IDLE;
        owner_next = 2'b00;
      end
      default: begin
        state_next = IDLE;
        owner_next = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      owner_reg <= 2'b00;
      addr_reg  <= 32'd0;
      wd_reg    <= 32'd0;
      we_reg    <= 1'b0;
      st_reg    <= 3'd0;
      rd_q_reg  <= 32'd0;
`ifndef ARB_FIXED_PRIO_EN
      last_grant_m1_reg <= 1'b1;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      owner_reg <= owner_next;
      addr_reg  <= addr_next;
      wd_reg    <= wd_next;
      we_reg    <= we_next;
      st_reg    <= st_next;
      rd_q_reg  <= rd_q_next;
`ifndef ARB_FIXED_PRIO_EN
      last_grant_m1_reg <= last_grant_m1_next;
`endif
    end
  end

  // Bus is driven only during XFER, from the latched copy of the winner's request.
  logic xfer_active;
  assign xfer_active = (state_reg == XFER);
  assign pr_addr     = xfer_active ? addr_reg : 32'd0;
  assign pr_wd       = xfer_active ? wd_reg   : 32'd0;
  assign store_type  = xfer_active ? st_reg   : 3'd0;
  assign mem_wr      = xfer_active && we_reg && (cnt_reg == 4'd0);
  assign gnt         = owner_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign ready_vec[gi] = (state_reg == RESP) && owner_reg[gi];
    end
  endgenerate

  assign m0_ready = ready_vec[0];
  assign m1_ready = ready_vec[1];
  assign m0_rd    = rd_q_reg;
  assign m1_rd    = rd_q_reg;

endmodule

// File: tb/tb_bridge_arbiter.sv
// Directed self-checking bench for bridge_arbiter (WAIT_CYCLES=2).
module tb_bridge_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wd, m1_addr, m1_wd, pr_rd;
  logic [2:0]  m0_storetype, m1_storetype;
  logic        m0_ready, m1_ready, mem_wr;
  logic [31:0] m0_rd, m1_rd, pr_addr, pr_wd;
  logic [2:0]  store_type;
  logic [1:0]  gnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bridge_arbiter #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wd(m0_wd), .m0_we(m0_we),
    .m0_storetype(m0_storetype), .m0_ready(m0_ready), .m0_rd(m0_rd),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wd(m1_wd), .m1_we(m1_we),
    .m1_storetype(m1_storetype), .m1_ready(m1_ready), .m1_rd(m1_rd),
    .pr_addr(pr_addr), .pr_wd(pr_wd), .mem_wr(mem_wr), .store_type(store_type),
    .pr_rd(pr_rd), .gnt(gnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("[TB] check %s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_idle_bus(input string tag);
    chk({tag, ".pr_addr"}, pr_addr, 32'd0);
    chk({tag, ".mem_wr"}, {31'd0, mem_wr}, 32'd0);
    chk({tag, ".store_type"}, {29'd0, store_type}, 32'd0);
  endtask

  initial begin
    logic exp_m1;
    reset_n = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wd = 0; m0_storetype = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wd = 0; m1_storetype = 0;
    pr_rd = 0;
    step(); step();
    chk("rst.gnt", {30'd0, gnt}, 32'd0);
    chk("rst.m0_ready", {31'd0, m0_ready}, 32'd0);
    chk_idle_bus("rst");
    reset_n = 1'b1;
    step();

    // Test 1: M0 write sw to 0x7F04
    m0_req = 1; m0_addr = 32'h7F04; m0_wd = 32'h10; m0_we = 1; m0_storetype = 3'b011;
    chk("t1.T.gnt", {30'd0, gnt}, 32'd0);
    step();
    chk("t1.T1.pr_addr", pr_addr, 32'h7F04);
    chk("t1.T1.pr_wd", pr_wd, 32'h10);
    chk("t1.T1.mem_wr", {31'd0, mem_wr}, 32'd1);
    chk("t1.T1.store_type", {29'd0, store_type}, 32'd3);
    chk("t1.T1.gnt", {30'd0, gnt}, 32'd1);
    chk("t1.T1.m0_ready", {31'd0, m0_ready}, 32'd0);
    step();
    chk("t1.T2.mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("t1.T2.store_type", {29'd0, store_type}, 32'd3);
    chk("t1.T2.gnt", {30'd0, gnt}, 32'd1);
    chk("t1.T2.m0_ready", {31'd0, m0_ready}, 32'd0);
    step();
    chk("t1.T3.m0_ready", {31'd0, m0_ready}, 32'd1);
    chk("t1.T3.gnt", {30'd0, gnt}, 32'd1);
    chk_idle_bus("t1.T3");
    m0_req = 0;
    step();
    chk("t1.T4.m0_ready", {31'd0, m0_ready}, 32'd0);
    chk("t1.T4.gnt", {30'd0, gnt}, 32'd0);

    // Test 2: M1 read 0x7F14
    m1_req = 1; m1_addr = 32'h7F14; m1_wd = 32'hDEAD; m1_we = 0; m1_storetype = 3'b000;
    step();
    chk("t2.T1.gnt", {30'd0, gnt}, 32'd2);
    chk("t2.T1.pr_addr", pr_addr, 32'h7F14);
    chk("t2.T1.mem_wr", {31'd0, mem_wr}, 32'd0);
    pr_rd = 32'h12345678;
    step();
    chk("t2.T2.mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("t2.T2.m1_ready", {31'd0, m1_ready}, 32'd0);
    step();
    chk("t2.T3.m1_ready", {31'd0, m1_ready}, 32'd1);
    chk("t2.T3.m1_rd", m1_rd, 32'h12345678);
    chk("t2.T3.m0_ready", {31'd0, m0_ready}, 32'd0);
    m1_req = 0; pr_rd = 0;
    step();
    chk("t2.T4.m1_ready", {31'd0, m1_ready}, 32'd0);

    // Test 6: master input changes during XFER are ignored
    m0_req = 1; m0_addr = 32'h7F04; m0_we = 0; m0_storetype = 3'b011;
    step();
    m0_req = 0; m0_addr = 32'h7F10;
    chk("t6.T1.pr_addr", pr_addr, 32'h7F04);
    step();
    chk("t6.T2.pr_addr", pr_addr, 32'h7F04);
    step();
    chk("t6.T3.m0_ready", {31'd0, m0_ready}, 32'd1);
    step();
    chk("t6.T4.gnt", {30'd0, gnt}, 32'd0);
    step();
    chk("t6.T5.gnt", {30'd0, gnt}, 32'd0);

    // Test 5: reset during XFER discards the transaction
    m0_req = 1; m0_addr = 32'h7F20; m0_wd = 32'hAA; m0_we = 1; m0_storetype = 3'b011;
    step();
    chk("t5.T1.mem_wr", {31'd0, mem_wr}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("t5.rst.gnt", {30'd0, gnt}, 32'd0);
    chk_idle_bus("t5.rst");
    step();
    chk("t5.rst.m0_ready", {31'd0, m0_ready}, 32'd0);
    step();
    chk("t5.rst2.m0_ready", {31'd0, m0_ready}, 32'd0);
    reset_n = 1'b1;
    step();
    chk("t5.R1.mem_wr", {31'd0, mem_wr}, 32'd1);
    chk("t5.R1.pr_addr", pr_addr, 32'h7F20);
    step();
    chk("t5.R2.mem_wr", {31'd0, mem_wr}, 32'd0);
    step();
    chk("t5.R3.m0_ready", {31'd0, m0_ready}, 32'd1);
    chk("t5.R3.mem_wr", {31'd0, mem_wr}, 32'd0);
    m0_req = 0;
    step();

    // Test 3/4: both masters request continuously from reset
    reset_n = 1'b0;
    step();
    m0_req = 1; m0_addr = 32'h100; m0_we = 0;
    m1_req = 1; m1_addr = 32'h200; m1_we = 0;
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_FIXED_PRIO_EN
      exp_m1 = 1'b0;
`else
      exp_m1 = (k % 2) == 1;
`endif
      step();
      chk($sformatf("t3.%0d.gnt", k), {30'd0, gnt}, exp_m1 ? 32'd2 : 32'd1);
      chk($sformatf("t3.%0d.pr_addr", k), pr_addr, exp_m1 ? 32'h200 : 32'h100);
      step();
      step();
      chk($sformatf("t3.%0d.m0_ready", k), {31'd0, m0_ready}, exp_m1 ? 32'd0 : 32'd1);
      chk($sformatf("t3.%0d.m1_ready", k), {31'd0, m1_ready}, exp_m1 ? 32'd1 : 32'd0);
      step();
      chk($sformatf("t3.%0d.idle_gnt", k), {30'd0, gnt}, 32'd0);
    end
    m0_req = 0; m1_req = 0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
